// File: rtl/reg_write_bank_if.sv
// Write-port bundle for reg_write_bank: one write request per clock in,
// the flattened register contents and the registered status pulses out.
interface reg_write_bank_if #(
  parameter int ADDR_W   = 5,
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32
);
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [NUM_REGS*WIDTH-1:0] regs_out;
  logic                      wr_ack;
  logic                      wr_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  regs_out, wr_ack, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output regs_out, wr_ack, wr_err
  );
endinterface

// File: rtl/reg_write_bank.sv
// Write side of the CPU register file: a structural demux-tree address decoder,
// the register array with mux2_1 hold feedback, and registered ack/err pulses.
module mux2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module demux1_2 (
  input  logic d,
  input  logic sel,
  output logic y0,
  output logic y1
);
  assign y0 = d & ~sel;
  assign y1 = d & sel;
endmodule

module reg_write_bank #(
  parameter int  NUM_REGS = 32,
  parameter int  ADDR_W   = 5,
  parameter int  WIDTH    = 64,
  parameter int  ZERO_REG = 31,
  parameter real DELAY    = 0.05
) (
  input  logic             clk,
  input  logic             reset_n,
  reg_write_bank_if.slave  bus
);
  localparam int NUM_DEC   = 2 ** ADDR_W;
  localparam int NUM_NODES = 2 * NUM_DEC - 1;

  if (NUM_REGS < 2 || NUM_REGS > NUM_DEC || ZERO_REG < 0 || ZERO_REG >= NUM_DEC ||
      DELAY * real'(ADDR_W + 1) <= 0.0) begin : g_param_check
    $error("reg_write_bank: illegal parameter combination");
  end

  // Heap-ordered demux tree: node n feeds 2n+1 / 2n+2, MSB of the address at the root,
  // so leaf NUM_DEC-1+a is the one-hot output for address a.
  logic [NUM_NODES-1:0] node;
  logic [NUM_DEC-1:0]   dec;

  assign node[0] = bus.wr_en;

  for (genvar lvl = 0; lvl < ADDR_W; lvl++) begin : g_lvl
    for (genvar i = 0; i < 2 ** lvl; i++) begin : g_node
      localparam int N = 2 ** lvl - 1 + i;
      demux1_2 u_dmx (
        .d   (node[N]),
        .sel (bus.wr_addr[ADDR_W-1-lvl]),
        .y0  (node[2*N+1]),
        .y1  (node[2*N+2])
      );
    end
  end

  assign dec = node[NUM_NODES-1 -: NUM_DEC];

  // Leaves past the last register are not wasted: they flag out-of-range writes.
  logic oor;
  if (NUM_REGS < NUM_DEC) begin : g_oor
    assign oor = |dec[NUM_DEC-1:NUM_REGS];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  logic zero_hit;
  logic reject;
  logic commit;

  assign zero_hit = dec[ZERO_REG];
  assign reject   = zero_hit | oor;
  assign commit   = bus.wr_en & ~reject;

  logic [NUM_REGS*WIDTH-1:0] regs_flat;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign regs_flat[r*WIDTH +: WIDTH] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] d;
      logic             en;

      assign en = dec[r] & bus.wr_en;

      mux2_1 #(.WIDTH(WIDTH)) u_fb (
        .d0  (q),
        .d1  (bus.wr_data),
        .sel (en),
        .y   (d)
      );

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= d;
      end

      assign regs_flat[r*WIDTH +: WIDTH] = q;
    end
  end

  assign bus.regs_out = regs_flat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_ack <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_ack <= commit;
      bus.wr_err <= reject;
    end
  end
endmodule
